// File: rtl/mux_reg_arbiter_pkg.sv
// mux_reg_arbiter_pkg
// Shared definitions for the two-requester muxed-register arbiter:
//   - state_t    : arbiter FSM states (IDLE, GRANT, HOLD)
//   - SRC0/SRC1  : requester encodings, also the mux select values
//   - HOLD_CNT_W : width of the post-load hold counter
package mux_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/mux_reg_arbiter_mux.sv
// mux_dff
// Shared register fed by a 2:1 mux. It loads only when en is high, so the
// arbiter owns exactly when the register changes.
// Ports:
//   clk  - clock, all updates on posedge
//   rst  - synchronous active-high reset, clears q
//   en   - load enable
//   sel  - 0 selects d0, 1 selects d1
//   d0   - input word 0
//   d1   - input word 1
//   q    - registered output
module mux_dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= sel ? d1 : d0;
        end
    end

endmodule

// File: rtl/mux_reg_arbiter.sv
// mux_reg_arbiter
// Arbitrates two requesters onto a shared 2:1 muxed register. A request
// seen in IDLE produces a one-cycle grant (GRANT); the register loads at the
// end of that cycle, q_valid pulses, and the block then rests for
// HOLD_CYCLES cycles (HOLD) before it looks at requests again.
//
// Optional feature: define MUXREG_ARB_FIXED_PRIO_EN to make ties always go
// to requester 0. Without it, ties go to the requester not served last.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   req0, d0      - requester 0 request and data
//   req1, d1      - requester 1 request and data
//   gnt0, gnt1    - registered one-cycle grant pulses
//   sel           - mux select of the shared register
//   q             - shared register contents
//   q_valid       - one-cycle pulse after each load
//   q_src         - requester whose word is currently in q
//   busy          - high whenever the FSM is not in IDLE
module mux_reg_arbiter
    import mux_reg_arbiter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             q_src,
    output logic             busy
);

    localparam int HOLD_INIT_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(HOLD_INIT_I);

    state_t                state, state_n;
    logic [HOLD_CNT_W-1:0] cnt, cnt_n;
    logic                  gnt0_n, gnt1_n, sel_n;
    logic                  q_valid_n, q_src_n;
    logic                  last_src, last_src_n;
    logic                  pick;
    logic                  load_en;

    // Winner of the current request set.
    always_comb begin
        pick = req0 ? SRC0 : SRC1;
`ifdef MUXREG_ARB_FIXED_PRIO_EN
        // Ties resolve to requester 0; pick already does that.
`else
        if (req0 && req1) begin
            pick = ~last_src;
        end
`endif
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gnt0_n     = 1'b0;
        gnt1_n     = 1'b0;
        sel_n      = sel;
        q_valid_n  = 1'b0;
        q_src_n    = q_src;
        last_src_n = last_src;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_n = GRANT;
                    sel_n   = pick;
                    gnt0_n  = (pick == SRC0);
                    gnt1_n  = (pick == SRC1);
                end
            end
            GRANT: begin
                // The register loads at the end of this cycle; sel names the winner.
                q_valid_n  = 1'b1;
                q_src_n    = sel;
                last_src_n = sel;
                if (HOLD_CYCLES > 0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_INIT;
                end else begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - HOLD_CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            q_valid  <= 1'b0;
            q_src    <= 1'b0;
            last_src <= SRC1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gnt0     <= gnt0_n;
            gnt1     <= gnt1_n;
            sel      <= sel_n;
            q_valid  <= q_valid_n;
            q_src    <= q_src_n;
            last_src <= last_src_n;
        end
    end

    assign load_en = (state == GRANT);
    assign busy    = (state != IDLE);

    mux_dff #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .sel (sel),
        .d0  (d0),
        .d1  (d1),
        .q   (q)
    );

endmodule
